wb_stage: RTL

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_pkg.sv | 25 ++
 rtl/wb_stage_if.sv | 26 ++
 rtl/wb_lane_reg.sv | 23 ++
 rtl/wb_stage.sv | 112 +++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared register-file definitions and lane payload type for the writeback stage.
package wb_stage_pkg;

  localparam int unsigned REG_ADDR_BUS = 5;
  localparam int unsigned REG_BUS      = 32;
  localparam int unsigned RETIRE_W     = 2;
  localparam int unsigned INSTRET_W    = 32;
  localparam int unsigned WAW_CNT_W    = 16;

  localparam logic               WRITE_ENABLE = 1'b1;
  localparam logic               RST_ENABLE   = 1'b0;
  localparam logic [REG_BUS-1:0] ZERO_WORD    = '0;

  typedef struct packed {
    logic                    we;
    logic [REG_ADDR_BUS-1:0] wa;
    logic [REG_BUS-1:0]      wdata;
  } lane_t;

  // A lane only touches the register file when enabled and not aimed at r0.
  function automatic logic lane_writes(input lane_t l);
    return (l.we == WRITE_ENABLE) && (l.wa != REG_ADDR_BUS'(0));
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM -> WB handshake carrying one instruction pair (lane2 is the younger).
interface wb_stage_if;
  import wb_stage_pkg::*;

  logic                    mem_valid;
  logic                    mem_ready;
  logic                    mem_inst1_we;
  logic [REG_ADDR_BUS-1:0] mem_inst1_wa;
  logic [REG_BUS-1:0]      mem_inst1_wdata;
  logic                    mem_inst2_we;
  logic [REG_ADDR_BUS-1:0] mem_inst2_wa;
  logic [REG_BUS-1:0]      mem_inst2_wdata;

  modport master (
    output mem_valid, mem_inst1_we, mem_inst1_wa, mem_inst1_wdata,
           mem_inst2_we, mem_inst2_wa, mem_inst2_wdata,
    input  mem_ready
  );

  modport slave (
    input  mem_valid, mem_inst1_we, mem_inst1_wa, mem_inst1_wdata,
           mem_inst2_we, mem_inst2_wa, mem_inst2_wdata,
    output mem_ready
  );

endinterface

// File: rtl/wb_lane_reg.sv
// Per-lane capture register for the writeback pair.
module wb_lane_reg
  import wb_stage_pkg::*;
(
  input  logic  clk,
  input  logic  resetn,
  input  logic  load,
  input  lane_t d,
  output lane_t q
);

  // Capture lane fields on load; cleared asynchronously on reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (resetn == RST_ENABLE) begin
      q.we    <= 1'b0;
      q.wa    <= REG_ADDR_BUS'(0);
      q.wdata <= ZERO_WORD;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: holds one instruction pair and drives the register-file
// write ports. Optional feature macro: WB_WAW_CNT_EN adds a saturating
// counter of cycles where a same-address lane1 write is suppressed.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetn,
  wb_stage_if.slave               mem,
  input  logic                    flush,
  input  logic                    wb_stall,
  output logic                    inst1_we,
  output logic [REG_ADDR_BUS-1:0] inst1_wa,
  output logic [REG_BUS-1:0]      inst1_w2regdata,
  output logic                    inst2_we,
  output logic [REG_ADDR_BUS-1:0] inst2_wa,
  output logic [REG_BUS-1:0]      inst2_w2regdata,
  output logic [RETIRE_W-1:0]     retire_cnt,
  output logic [INSTRET_W-1:0]    instret
`ifdef WB_WAW_CNT_EN
  ,
  output logic [WAW_CNT_W-1:0]    waw_cnt
`endif
);

  logic                 valid_q;
  lane_t                lane1_d, lane2_d;
  lane_t                lane1_q, lane2_q;
  logic                 retire_c;
  logic                 capture_c;
  logic                 waw_c;
  logic [INSTRET_W-1:0] instret_q;

  assign mem.mem_ready = ~valid_q | ~wb_stall;

  assign lane1_d = lane_t'{we: mem.mem_inst1_we, wa: mem.mem_inst1_wa, wdata: mem.mem_inst1_wdata};
  assign lane2_d = lane_t'{we: mem.mem_inst2_we, wa: mem.mem_inst2_wa, wdata: mem.mem_inst2_wdata};

  // Retire, capture and same-address conflict decode; flush masks both.
  always_comb begin
    retire_c  = valid_q & ~wb_stall & ~flush;
    capture_c = mem.mem_valid & mem.mem_ready & ~flush;
    waw_c     = lane_writes(lane1_q) & lane_writes(lane2_q) & (lane1_q.wa == lane2_q.wa);
  end

  wb_lane_reg u_lane1 (
    .clk    (clk),
    .resetn (resetn),
    .load   (capture_c),
    .d      (lane1_d),
    .q      (lane1_q)
  );

  wb_lane_reg u_lane2 (
    .clk    (clk),
    .resetn (resetn),
    .load   (capture_c),
    .d      (lane2_d),
    .q      (lane2_q)
  );

  // Pair occupancy: flush wins, a new capture refills, retirement empties.
  always_ff @(posedge clk or negedge resetn) begin
    if (resetn == RST_ENABLE) begin
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (capture_c) begin
      valid_q <= 1'b1;
    end else if (retire_c) begin
      valid_q <= 1'b0;
    end
  end

  // Register-file write ports; lane2 wins a same-address conflict.
  always_comb begin
    inst1_we        = retire_c & lane_writes(lane1_q) & ~waw_c;
    inst1_wa        = lane1_q.wa;
    inst1_w2regdata = lane1_q.wdata;
    inst2_we        = retire_c & lane_writes(lane2_q);
    inst2_wa        = lane2_q.wa;
    inst2_w2regdata = lane2_q.wdata;
    retire_cnt      = retire_c ? RETIRE_W'(2) : RETIRE_W'(0);
  end

  // Running retired-instruction count, wraps naturally.
  always_ff @(posedge clk or negedge resetn) begin
    if (resetn == RST_ENABLE) begin
      instret_q <= INSTRET_W'(0);
    end else begin
      instret_q <= instret_q + INSTRET_W'(retire_cnt);
    end
  end

  assign instret = instret_q;

`ifdef WB_WAW_CNT_EN
  logic [WAW_CNT_W-1:0] waw_cnt_q;

  // Saturating count of cycles where lane1's write is actually suppressed.
  always_ff @(posedge clk or negedge resetn) begin
    if (resetn == RST_ENABLE) begin
      waw_cnt_q <= WAW_CNT_W'(0);
    end else if (retire_c && waw_c && (waw_cnt_q != {WAW_CNT_W{1'b1}})) begin
      waw_cnt_q <= waw_cnt_q + WAW_CNT_W'(1);
    end
  end

  assign waw_cnt = waw_cnt_q;
`endif

endmodule
